ne16_normquant_param_loader: RTL and testbench
==============================================

# ne16_normquant_param_loader

- Receives normalization parameters from the NE16 streamer as 32-bit words over a valid/ready stream.
- Deserializes them into per-channel bias and shift registers.
- Holds those registers stable and presents them, with a valid flag, to the normquant bias/shift stage (`norm_bias`, `shift` inputs).
- It is the producer side of that parameter interface and sits between the streamer sink and the normquant datapath of the accumulator.

## Interface
- `NADD`, 8: channels per parameter set.
- `ACC`, 32: bias lane width; must be ≤ 32.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `clear_i` in 1: synchronous local clear.
- `start_i` in 1: begin loading a parameter set.
- `nch_i` in $clog2(NADD+1): active channel count, sampled on accepted `start_i`.
- `shift_common_i` in 8: shift applied to all lanes when per-channel shift is compiled out.
- `stream_valid_i` in 1: stream word valid.
- `stream_ready_o` out 1: stream word accepted.
- `stream_data_i` in 32: stream word.
- `norm_bias_o` out NADD*ACC: lane i at [(i+1)*ACC-1:i*ACC].
- `shift_o` out NADD*8: lane i at [(i+1)*8-1:i*8].
- `params_valid_o` out 1: parameter set complete and stable.
- `params_release_i` in 1: consumer done with the current set.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- **States:** IDLE, LOAD_BIAS, LOAD_SHIFT, VALID.
- **IDLE + `start_i`:**
  - Latch `nch = min(nch_i, NADD)`.
  - Zero all bias and shift lanes.
  - Clear the word counter.
  - Go to LOAD_BIAS; if `nch == 0`, go directly to VALID.
- **LOAD_BIAS:**
  - One word per channel, channel 0 first.
  - On handshake, bias lane[cnt] = `stream_data_i[ACC-1:0]` and cnt++.
  - After word `nch-1`: clear cnt and go to LOAD_SHIFT, or to VALID if per-channel shift is compiled out.
- **LOAD_SHIFT:**
  - `ceil(nch/4)` words.
  - Byte b of word w goes to shift lane 4w+b.
  - Bytes for lanes ≥ `nch` (or ≥ NADD) are discarded.
  - After the last word, go to VALID.
- **VALID:**
  - `params_valid_o` = 1 and outputs are frozen.
  - `params_release_i` → IDLE.
  - `params_release_i` and `start_i` in the same cycle → LOAD_BIAS directly (back-to-back), with the same zeroing and latching as IDLE.
- `start_i` in LOAD_BIAS, LOAD_SHIFT or IDLE-less states is ignored, except in the VALID+release case above.
- `params_release_i` outside VALID is ignored.
- **`clear_i`:**
  - Highest priority over every other input.
  - Next state IDLE; all lanes, cnt and `nch` are zeroed.
  - Any in-flight stream word is not consumed.
- Lanes ≥ `nch` read as zero bias and zero shift.
- Word count is deterministic: `nch + ceil(nch/4)` words with per-channel shift compiled in, `nch` without. Extra stream words are not accepted.

## Timing
- **Reset values:**
  - `stream_ready_o` = 0, `params_valid_o` = 0, `busy_o` = 0.
  - `norm_bias_o` = 0, `shift_o` = 0.
  - State IDLE.
- `stream_ready_o` is a combinational decode of state: 1 in LOAD_BIAS and LOAD_SHIFT only. It never depends on `stream_valid_i`.
- A handshake is `stream_valid_i & stream_ready_o` at a rising edge. The word is written at that edge.
- `params_valid_o` rises the cycle after the final handshake.
- `params_valid_o` falls the cycle after release or clear.
- `norm_bias_o` and `shift_o` are driven directly from registers, with no combinational path from inputs.
- Stalls (`stream_valid_i` = 0) hold state and cnt indefinitely.
- Minimum load latency, `start_i` to `params_valid_o`: `1 + nch + ceil(nch/4)` cycles at full throughput, or 1 cycle for `nch` = 0.

## Configuration
- Macro: `NE16_NQ_PERCH_SHIFT_EN`.
- **Defined:**
  - LOAD_SHIFT state exists.
  - Shift lanes are streamed per channel as above.
  - `shift_common_i` is unused.
- **Undefined:**
  - LOAD_SHIFT is never entered; LOAD_BIAS → VALID.
  - On accepted `start_i`, every lane < `nch` gets `shift_common_i`; other lanes get 0.
  - Stream word count is `nch`.

## Structure
- **Add to `ne16_package`:**
  - Enum `ne16_nq_loader_state_t` {IDLE, LOAD_BIAS, LOAD_SHIFT, VALID}.
  - Constant `NE16_NQ_SHIFT_PER_WORD = 4`.
- **Sub-module `ne16_nq_param_regfile`:** NADD-lane bias/shift register bank with the following ports:
  - Clear.
  - Indexed bias write.
  - Indexed 4-byte shift write with lane mask.
  - Broadcast shift write.
- The FSM, counter and handshake logic live in the top module.

## Test plan
- **Basic load:**
  - Stimulus: `nch`=8, per-channel shift; bias words 0x10..0x17, shift words 0x03020100, 0x07060504, `stream_valid_i` held high.
  - Required: `params_valid_o` 11 cycles after start, lane i bias = 0x10+i, shift = i.
- **Partial set:**
  - Stimulus: `nch`=5.
  - Required: exactly 7 words accepted; lanes 5–7 are 0; lane-5..7 bytes of the second shift word are discarded.
- **Random stalls:**
  - Stimulus: random `stream_valid_i` deassertion.
  - Required: identical final contents to the basic load; `stream_ready_o` is stable during stalls.
- **Back-to-back:**
  - Stimulus: in VALID, assert `start_i` + `params_release_i` in the same cycle.
  - Required: `params_valid_o` drops the next cycle; state is LOAD_BIAS and lanes are zeroed.
- **Clear mid-load:**
  - Stimulus: `clear_i` after 3 bias words.
  - Required: IDLE next cycle, all outputs 0, and a subsequent full load is correct.
- **Macro undefined:**
  - Stimulus: `nch`=8, `shift_common_i`=9.
  - Required: 8 words accepted, all shift lanes = 9, `params_valid_o` 9 cycles after start.

Source files
------------

// File: rtl/ne16_package.sv
// ============================================================================
// ne16_package : shared types/constants for the NE16 normquant parameter path
// Rev 1.0
// ============================================================================
`default_nettype none

package ne16_package;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_BIAS  = 2'd1,
    LOAD_SHIFT = 2'd2,
    VALID      = 2'd3
  } ne16_nq_loader_state_t;

  localparam int NE16_NQ_SHIFT_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/ne16_nq_param_regfile.sv
// ============================================================================
// ne16_nq_param_regfile : NADD-lane bias/shift register bank
// Rev 1.0
// ============================================================================
`default_nettype none

module ne16_nq_param_regfile
  import ne16_package::*;
#(
  parameter int NADD = 8,
  parameter int ACC  = 32,
  parameter int IW   = $clog2(NADD + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              bias_we,
  input  logic [IW-1:0]                     bias_idx,
  input  logic [ACC-1:0]                    bias_data,
  input  logic                              shift_we,
  input  logic [IW-1:0]                     shift_word,
  input  logic [31:0]                       shift_data,
  input  logic [NE16_NQ_SHIFT_PER_WORD-1:0] shift_mask,
  input  logic                              bcast_we,
  input  logic [7:0]                        bcast_data,
  input  logic [NADD-1:0]                   bcast_mask,
  output logic [NADD*ACC-1:0]               norm_bias,
  output logic [NADD*8-1:0]                 shift
);

  localparam int SPW = NE16_NQ_SHIFT_PER_WORD;

  logic [NADD-1:0][ACC-1:0] bias_q;
  logic [NADD-1:0][7:0]     shift_q;

  assign norm_bias = bias_q;
  assign shift     = shift_q;

  // Writes in the same cycle as clear win, so a start can zero and broadcast at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q  <= '0;
      shift_q <= '0;
    end else begin
      if (clear) begin
        bias_q  <= '0;
        shift_q <= '0;
      end
      for (int i = 0; i < NADD; i++) begin
        if (bias_we && (32'(bias_idx) == i))
          bias_q[i] <= bias_data;
        if (shift_we && (32'(shift_word) == i / SPW) && shift_mask[i % SPW])
          shift_q[i] <= shift_data[8*(i % SPW) +: 8];
        if (bcast_we && bcast_mask[i])
          shift_q[i] <= bcast_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ne16_normquant_param_loader.sv
// ============================================================================
// ne16_normquant_param_loader : streams bias/shift words into stable per-channel
// normquant parameters. Option macro: NE16_NQ_PERCH_SHIFT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ne16_normquant_param_loader
  import ne16_package::*;
#(
  parameter int NADD = 8,
  parameter int ACC  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [$clog2(NADD+1)-1:0]    nch_i,
  input  logic [7:0]                   shift_common_i,
  input  logic                         stream_valid_i,
  output logic                         stream_ready_o,
  input  logic [31:0]                  stream_data_i,
  output logic [NADD*ACC-1:0]          norm_bias_o,
  output logic [NADD*8-1:0]            shift_o,
  output logic                         params_valid_o,
  input  logic                         params_release_i,
  output logic                         busy_o
);

  localparam int CW  = $clog2(NADD + 1);
  localparam int SPW = NE16_NQ_SHIFT_PER_WORD;

  ne16_nq_loader_state_t state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nch;
  logic [CW-1:0]   nch_start;
  logic            hs;
  logic            start_acc;
  logic [SPW-1:0]  shift_mask;
  logic [NADD-1:0] lane_active;

  assign stream_ready_o = (state == LOAD_BIAS) || (state == LOAD_SHIFT);
  assign hs             = stream_valid_i && stream_ready_o && !clear_i;
  assign start_acc      = start_i && !clear_i &&
                          ((state == IDLE) || ((state == VALID) && params_release_i));
  assign nch_start      = (32'(nch_i) > NADD) ? CW'(NADD) : nch_i;

`ifdef NE16_NQ_PERCH_SHIFT_EN
  logic [CW-1:0] last_shift_word;
  assign last_shift_word = CW'((32'(nch) + SPW - 1) / SPW - 1);
`endif

  // Byte lanes beyond the active channel count are masked off inside a shift word.
  always_comb begin
    shift_mask  = '0;
    lane_active = '0;
    for (int b = 0; b < SPW; b++)
      shift_mask[b] = (32'(cnt) * SPW + b) < 32'(nch);
    for (int i = 0; i < NADD; i++)
      lane_active[i] = i < 32'(nch_start);
  end

  ne16_nq_param_regfile #(
    .NADD (NADD),
    .ACC  (ACC),
    .IW   (CW)
  ) u_regfile (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (clear_i || start_acc),
    .bias_we    (hs && (state == LOAD_BIAS)),
    .bias_idx   (cnt),
    .bias_data  (stream_data_i[ACC-1:0]),
`ifdef NE16_NQ_PERCH_SHIFT_EN
    .shift_we   (hs && (state == LOAD_SHIFT)),
    .bcast_we   (1'b0),
`else
    .shift_we   (1'b0),
    .bcast_we   (start_acc),
`endif
    .shift_word (cnt),
    .shift_data (stream_data_i),
    .shift_mask (shift_mask),
    .bcast_data (shift_common_i),
    .bcast_mask (lane_active),
    .norm_bias  (norm_bias_o),
    .shift      (shift_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      nch            <= '0;
      params_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (clear_i) begin
      state          <= IDLE;
      cnt            <= '0;
      nch            <= '0;
      params_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (start_acc) begin
      nch    <= nch_start;
      cnt    <= '0;
      busy_o <= 1'b1;
      if (nch_start == '0) begin
        state          <= VALID;
        params_valid_o <= 1'b1;
      end else begin
        state          <= LOAD_BIAS;
        params_valid_o <= 1'b0;
      end
    end else begin
      case (state)
        LOAD_BIAS: begin
          if (hs) begin
            if (cnt == nch - CW'(1)) begin
              cnt <= '0;
`ifdef NE16_NQ_PERCH_SHIFT_EN
              state <= LOAD_SHIFT;
`else
              state          <= VALID;
              params_valid_o <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`ifdef NE16_NQ_PERCH_SHIFT_EN
        LOAD_SHIFT: begin
          if (hs) begin
            if (cnt == last_shift_word) begin
              cnt            <= '0;
              state          <= VALID;
              params_valid_o <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`endif
        VALID: begin
          if (params_release_i) begin
            state          <= IDLE;
            params_valid_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ne16_normquant_param_loader.sv
// ============================================================================
// tb_ne16_normquant_param_loader : randomized directed bench with reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ne16_normquant_param_loader;

  localparam int NADD = 8;
  localparam int ACC  = 32;
`ifdef NE16_NQ_PERCH_SHIFT_EN
  localparam bit PERCH = 1'b1;
`else
  localparam bit PERCH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   nch = '0;
  logic [7:0]   common = '0;
  logic         sv = 1'b0;
  logic         sr;
  logic [31:0]  sd = '0;
  logic [255:0] bias;
  logic [63:0]  shift;
  logic         pv;
  logic         rel = 1'b0;
  logic         busy;

  int tests = 0;
  int failed = 0;
  logic [31:0] words[$];

  always #5 clk = ~clk;

  ne16_normquant_param_loader #(.NADD(NADD), .ACC(ACC)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clear),
    .start_i          (start),
    .nch_i            (nch),
    .shift_common_i   (common),
    .stream_valid_i   (sv),
    .stream_ready_o   (sr),
    .stream_data_i    (sd),
    .norm_bias_o      (bias),
    .shift_o          (shift),
    .params_valid_o   (pv),
    .params_release_i (rel),
    .busy_o           (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected parameter set: first n words are biases, then packed shift bytes (or the common shift).
  function automatic void model(input int n, input logic [7:0] cm,
                                output logic [255:0] eb, output logic [63:0] es);
    logic [31:0] w;
    eb = '0;
    es = '0;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      eb[i*32 +: 32] = w;
      if (PERCH) begin
        w = words[n + i/4];
        es[i*8 +: 8] = w[(i%4)*8 +: 8];
      end else begin
        es[i*8 +: 8] = cm;
      end
    end
  endfunction

  task automatic fill_random(input int count);
    words.delete();
    for (int k = 0; k < count; k++) words.push_back($urandom);
  endtask

  task automatic fill_basic();
    words.delete();
    for (int k = 0; k < 8; k++) words.push_back(32'h10 + k);
    if (PERCH) begin
      words.push_back(32'h03020100);
      words.push_back(32'h07060504);
    end
  endtask

  task automatic run_load(input string tag, input int n_req, input logic [7:0] cm,
                          input int stall_pct, input bit b2b);
    int n, nw, widx, lat, extra;
    bit rdy, done;
    logic [255:0] eb;
    logic [63:0]  es;
    n  = (n_req > NADD) ? NADD : n_req;
    nw = n + (PERCH ? (n + 3) / 4 : 0);
    model(n, cm, eb, es);
    nch = 4'(n_req);
    common = cm;
    start = 1'b1;
    rel = b2b;
    sv = 1'b0;
    step();
    start = 1'b0;
    rel = 1'b0;
    lat = 1;
    widx = 0;
    if (n > 0) begin
      chk({tag, "_start_valid"}, 256'(pv), 256'(0));
      chk({tag, "_start_ready"}, 256'(sr), 256'(1));
      chk({tag, "_start_bias"}, bias, 256'(0));
      chk({tag, "_start_shift"}, 256'(shift), PERCH ? 256'(0) : 256'(es));
    end
    done = pv;
    while (!done && lat < 300) begin
      sv = ($urandom_range(99) >= stall_pct);
      sd = (widx < words.size()) ? words[widx] : $urandom;
      rdy = sr;
      if (sv && sr) widx++;
      step();
      lat++;
      if (!sv && rdy && !pv) chk({tag, "_ready_stall"}, 256'(sr), 256'(1));
      done = pv;
    end
    chk({tag, "_valid"}, 256'(pv), 256'(1));
    if (stall_pct == 0) chk({tag, "_latency"}, 256'(lat), 256'(1 + nw));
    chk({tag, "_accepted"}, 256'(widx), 256'(nw));
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      sv = 1'b1;
      sd = $urandom;
      if (sr) extra++;
      step();
    end
    sv = 1'b0;
    chk({tag, "_extra_words"}, 256'(extra), 256'(0));
    chk({tag, "_bias"}, bias, eb);
    chk({tag, "_shift"}, 256'(shift), 256'(es));
    chk({tag, "_busy"}, 256'(busy), 256'(1));
  endtask

  task automatic do_release(input string tag);
    rel = 1'b1;
    step();
    rel = 1'b0;
    chk({tag, "_rel_valid"}, 256'(pv), 256'(0));
    chk({tag, "_rel_busy"}, 256'(busy), 256'(0));
    chk({tag, "_rel_ready"}, 256'(sr), 256'(0));
  endtask

  initial begin
    #1;
    chk("reset_ready", 256'(sr), 256'(0));
    chk("reset_valid", 256'(pv), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_bias", bias, 256'(0));
    chk("reset_shift", 256'(shift), 256'(0));
    step();
    step();
    rst = 1'b0;
    step();

    fill_basic();
    run_load("basic", 8, 8'd9, 0, 1'b0);
    do_release("basic");

    fill_random(12);
    run_load("partial", 5, 8'(($urandom_range(15))), 0, 1'b0);
    do_release("partial");

    fill_basic();
    run_load("stall", 8, 8'd9, 40, 1'b0);
    do_release("stall");

    fill_random(12);
    run_load("clamp", 15, 8'd3, 0, 1'b0);
    do_release("clamp");

    fill_random(4);
    run_load("zero", 0, 8'd7, 0, 1'b0);
    do_release("zero");

    fill_random(12);
    run_load("pre_b2b", 3, 8'd2, 0, 1'b0);
    fill_random(12);
    run_load("b2b", 6, 8'd5, 25, 1'b1);
    do_release("b2b");

    // Clear after three bias words; the word offered during clear must not land.
    fill_random(12);
    nch = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    sv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sd = words[k];
      step();
    end
    chk("clr_partial_bias", 256'(bias[95:0]), 256'({words[2], words[1], words[0]}));
    sd = 32'hDEADBEEF;
    clear = 1'b1;
    step();
    clear = 1'b0;
    sv = 1'b0;
    chk("clr_valid", 256'(pv), 256'(0));
    chk("clr_busy", 256'(busy), 256'(0));
    chk("clr_ready", 256'(sr), 256'(0));
    chk("clr_bias", bias, 256'(0));
    chk("clr_shift", 256'(shift), 256'(0));
    step();
    chk("clr_idle_ready", 256'(sr), 256'(0));

    fill_random(12);
    run_load("after_clr", 8, 8'd11, 20, 1'b0);
    do_release("after_clr");

    for (int r = 0; r < 3; r++) begin
      fill_random(12);
      run_load("rand", int'($urandom_range(1, 8)), 8'($urandom), 30, 1'b0);
      do_release("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
